// File: rtl/peg_scorer_pkg.sv
// Shared Mastermind definitions: peg geometry, scorer FSM state codes, 3-bit count type.
package mastermind_pkg;

    localparam int NUM_PEGS  = 4;
    localparam int PEG_W_DEF = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_EXACT = 2'd1;
    localparam state_t ST_COUNT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Counts over four pegs never exceed 4, so 3 bits always suffice.
    typedef logic [2:0] cnt_t;

    function automatic cnt_t cnt_min(input cnt_t a, input cnt_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/peg_scorer_if.sv
// Request/result bundle between the history block and peg_scorer.
// Optional PEG_SCORER_WIN_EN adds the sticky win flag.
interface peg_scorer_if #(
    parameter int PEG_W = 3
);
    logic             start;
    logic [PEG_W-1:0] guess0, guess1, guess2, guess3;
    logic [PEG_W-1:0] secret0, secret1, secret2, secret3;
    logic             busy;
    logic             done;
    logic [2:0]       black;
    logic [2:0]       white;
`ifdef PEG_SCORER_WIN_EN
    logic             win;

    modport master (
        output start, guess0, guess1, guess2, guess3,
               secret0, secret1, secret2, secret3,
        input  busy, done, black, white, win
    );
    modport slave (
        input  start, guess0, guess1, guess2, guess3,
               secret0, secret1, secret2, secret3,
        output busy, done, black, white, win
    );
`else
    modport master (
        output start, guess0, guess1, guess2, guess3,
               secret0, secret1, secret2, secret3,
        input  busy, done, black, white
    );
    modport slave (
        input  start, guess0, guess1, guess2, guess3,
               secret0, secret1, secret2, secret3,
        output busy, done, black, white
    );
`endif
endinterface

// File: rtl/peg_scorer_color_counter.sv
// Combinational count of how many of the four pegs carry one colour.
module color_counter
    import mastermind_pkg::*;
#(
    parameter int PEG_W = PEG_W_DEF
) (
    input  logic [NUM_PEGS-1:0][PEG_W-1:0] pegs_i,
    input  logic [PEG_W-1:0]               color_i,
    output cnt_t                           count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < NUM_PEGS; i++)
            count_o = count_o + cnt_t'(pegs_i[i] == color_i);
    end
endmodule

// File: rtl/peg_scorer.sv
// Multi-cycle black/white scorer: one colour per cycle in COUNT.
// Define PEG_SCORER_WIN_EN to add the sticky win output.
module peg_scorer
    import mastermind_pkg::*;
#(
    parameter int NUM_COLORS = 8,
    parameter int PEG_W      = PEG_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    peg_scorer_if.slave bus
);
    typedef logic [NUM_PEGS-1:0][PEG_W-1:0] pegs_t;
    localparam logic [PEG_W-1:0] C_LAST = PEG_W'(NUM_COLORS - 1);

    state_t           state_q, state_d;
    pegs_t            guess_q, guess_d, secret_q, secret_d;
    logic [PEG_W-1:0] color_q, color_d;
    cnt_t             bacc_q, bacc_d, total_q, total_d;
    cnt_t             black_q, black_d, white_q, white_d;
    cnt_t             exact, cnt_g, cnt_s, cnt_m;
    logic             last_step;

    color_counter #(.PEG_W(PEG_W)) u_cnt_guess (
        .pegs_i (guess_q),
        .color_i(color_q),
        .count_o(cnt_g)
    );
    color_counter #(.PEG_W(PEG_W)) u_cnt_secret (
        .pegs_i (secret_q),
        .color_i(color_q),
        .count_o(cnt_s)
    );

    assign cnt_m     = cnt_min(cnt_g, cnt_s);
    assign last_step = (state_q == ST_COUNT) && (color_q == C_LAST);

    always_comb begin
        exact = '0;
        for (int i = 0; i < NUM_PEGS; i++)
            exact = exact + cnt_t'(guess_q[i] == secret_q[i]);
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        secret_d = secret_q;
        color_d  = color_q;
        bacc_d   = bacc_q;
        total_d  = total_q;
        black_d  = black_q;
        white_d  = white_q;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                guess_d  = {bus.guess3, bus.guess2, bus.guess1, bus.guess0};
                secret_d = {bus.secret3, bus.secret2, bus.secret1, bus.secret0};
                state_d  = ST_EXACT;
            end
            ST_EXACT: begin
                bacc_d  = exact;
                color_d = '0;
                total_d = '0;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                total_d = total_q + cnt_m;
                color_d = color_q + PEG_W'(1);
                // total covers every colour match; exact matches are not white.
                if (last_step) begin
                    black_d = bacc_q;
                    white_d = total_q + cnt_m - bacc_q;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            secret_q <= '0;
            color_q  <= '0;
            bacc_q   <= '0;
            total_q  <= '0;
            black_q  <= '0;
            white_q  <= '0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            secret_q <= secret_d;
            color_q  <= color_d;
            bacc_q   <= bacc_d;
            total_q  <= total_d;
            black_q  <= black_d;
            white_q  <= white_d;
        end
    end

    assign bus.busy  = (state_q == ST_EXACT) || (state_q == ST_COUNT);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.black = black_q;
    assign bus.white = white_q;

`ifdef PEG_SCORER_WIN_EN
    logic win_q, win_d;

    assign win_d = win_q | (last_step && (bacc_q == 3'd4));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) win_q <= 1'b0;
        else        win_q <= win_d;
    end

    assign bus.win = win_q;
`endif
endmodule

// File: doc/peg_scorer.md
# peg_scorer

Scores one four-peg guess against the four-peg secret code and produces black (right colour, right slot) and white (right colour, wrong slot) counts. It sits directly downstream of `history`: it consumes the committed or browsed guess on `selection0..3` and returns the feedback that the display shows for that turn. Scoring is a small multi-cycle FSM with a start/done handshake, which keeps the logic narrow.

## Interface
- `NUM_COLORS`, default 8: colours legal on a peg are 0..NUM_COLORS-1; must be ≤ 8.
- `PEG_W`, default 3: bit width of one peg.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- `start`  in  1  request to score; sampled only in IDLE.
- `guess0..guess3`  in  PEG_W each  guess pegs (driven from `selection0..3`).
- `secret0..secret3`  in  PEG_W each  secret code pegs.
- `busy`  out  1  high in EXACT and COUNT.
- `done`  out  1  single-cycle pulse when `black`/`white` are valid.
- `black`  out  3  positional matches, 0..4.
- `white`  out  3  colour-only matches, 0..4.
- `win`  out  1  only with PEG_SCORER_WIN_EN; see Configuration.

## Operation
- States: IDLE, EXACT, COUNT, DONE.
- IDLE, `start`=1 -> latch guess and secret into internal registers, go to EXACT. When `start`=0, stay in IDLE.
- EXACT: `black_acc` = number of slots i with guess_i == secret_i. Clear the colour index `c` and `total`. Go to COUNT.
- COUNT: `total` += min(count of c in guess, count of c in secret). Then c += 1.
  - When c == NUM_COLORS-1, register `black` = `black_acc` and `white` = total+min(c) − black_acc, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor allowed to restart scoring.
- Input changes after the latch edge do not affect the result in flight.
- `black`/`white` hold their last result until the next DONE.
- Widths: per-colour counts are 3 bits (0..4). `total` is 3 bits and saturates naturally at 4. `white` = total − black never underflows, because total ≥ black.
- Pegs with values ≥ NUM_COLORS are never counted for white. They can still count as black if they match positionally.

## Timing
- Reset (reset=0): state IDLE; `busy`=0, `done`=0, `black`=0, `white`=0, `win`=0; `c`, `total` and the latched pegs are all 0.
- Reset mid-operation aborts the score. No `done` is produced, and the outputs read 0.
- Latency: `start` sampled at edge E0.
  - EXACT at E0→E1, COUNT occupies NUM_COLORS cycles, DONE is entered at E(1+NUM_COLORS).
  - With default NUM_COLORS=8, `done` is high in the cycle after E9.
- `busy` rises in the cycle after E0 and falls in the same cycle that `done` rises.
- Back-to-back: the earliest next accepted `start` is sampled at the edge that leaves DONE+1, i.e. in IDLE.

## Configuration
- `PEG_SCORER_WIN_EN` defined:
  - Adds output `win`.
  - `win` is set on entering DONE with black==4.
  - `win` is sticky until reset and is unaffected by later scores.
- Not defined: the `win` port and its register are absent, with no other change.

## Structure
- Shared package `mastermind_pkg`:
  - `NUM_PEGS`=4 and the `PEG_W` default.
  - The state enum (IDLE/EXACT/COUNT/DONE).
  - The 3-bit count typedef.
- Sub-module `color_counter`: combinational count of one colour across four pegs, giving a 3-bit result. It is instantiated twice, once for the guess and once for the secret.

## Test plan
- secret 1-2-3-4, guess 1-2-3-4, start pulse -> `done` 9 cycles later, black=4, white=0, win=1 (if enabled).
- secret 1-2-3-4, guess 4-3-2-1 -> black=0, white=4.
- secret 1-1-2-2, guess 1-2-1-0 -> black=1, white=2.
- secret 5-5-5-5, guess 0-1-2-3 -> black=0, white=0, win stays 0.
- `start` asserted again 3 cycles into a score, and guess inputs changed mid-score -> exactly one `done`, with the result of the originally latched pegs.
- reset pulsed low during COUNT -> `busy`/`black`/`white`=0 immediately, no `done`; a following start scores normally.
